latch_bank_write_sequencer: RTL

Clocked write controller for the four-entry, 8-bit transparent-latch store driven from the board switches. It debounces the raw write button and snapshots the bank select and data byte. It then drives one bank's latch enable through a fixed setup / strobe / hold sequence, so a latch is only opened while its data is stable. Exactly one write is issued per debounced press. It sits between the board inputs and the store's enable/data demultiplexing; the store's read-back path is unchanged.

---
 rtl/latch_bank_write_sequencer.sv | 101 ++++++++++
 1 files changed

// File: rtl/latch_bank_write_sequencer.sv
// latch_bank_write_sequencer: debounced button to one setup/strobe/hold write into a 4x8 latch bank
module latch_bank_write_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SETUP_CYCLES = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic [1:0] sel_in,
  input  logic [7:0] data_in,
  output logic [7:0] wr_data,
  output logic [3:0] wr_en,
  output logic       busy,
  output logic       wr_done,
  output logic [7:0] wr_count
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE, RELEASE} state_t;
  state_t state, state_n;
  logic s1, s, db_level, db_level_q, armed, db_rise;
  logic [1:0] sv;
  logic [DW-1:0] db_cnt;
  logic [15:0] pcnt, pcnt_n;
  logic [1:0] sel_r, sel_n;
  logic [7:0] wr_data_n;
  logic [3:0] wr_en_n;
  logic busy_n, wr_done_n;
  // Synchronize and debounce the button. sv marks when s carries a real sample
  // after reset; armed only sets once the button is seen low, so a button held
  // through reset cannot trigger a write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s <= 1'b0;
      sv <= '0;
      armed <= 1'b0;
      db_level <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= btn;
      s <= s1;
      sv <= {sv[0], 1'b1};
      armed <= armed | (sv[1] & ~s);
      db_level_q <= db_level;
      if (s == db_level) db_cnt <= '0;
      else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        db_level <= s;
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  end
  assign db_rise = db_level & ~db_level_q & armed;
  // Next state, phase counter and next registered output values
  always_comb begin
    state_n = state;
    sel_n = sel_r;
    wr_data_n = wr_data;
    case (state)
      IDLE: if (db_rise) begin
        state_n = SETUP;
        sel_n = sel_in;
        wr_data_n = data_in;
      end
      SETUP: state_n = pcnt == 16'(SETUP_CYCLES - 1) ? STROBE : SETUP;
      STROBE: state_n = pcnt == 16'(STROBE_CYCLES - 1) ? HOLD : STROBE;
      HOLD: state_n = pcnt == 16'(HOLD_CYCLES - 1) ? DONE : HOLD;
      DONE: state_n = RELEASE;
      RELEASE: state_n = db_level ? RELEASE : IDLE;
      default: state_n = IDLE;
    endcase
    pcnt_n = state_n == state ? pcnt + 1'b1 : '0;
    wr_en_n = state_n == STROBE ? 4'b0001 << sel_r : 4'b0000;
    busy_n = state_n != IDLE;
    wr_done_n = state_n == DONE;
  end
  // State and output registers; wr_count advances on the edge closing DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pcnt <= '0;
      sel_r <= '0;
      wr_data <= '0;
      wr_en <= '0;
      busy <= 1'b0;
      wr_done <= 1'b0;
      wr_count <= '0;
    end else begin
      state <= state_n;
      pcnt <= pcnt_n;
      sel_r <= sel_n;
      wr_data <= wr_data_n;
      wr_en <= wr_en_n;
      busy <= busy_n;
      wr_done <= wr_done_n;
      wr_count <= wr_count + {7'd0, state == DONE};
    end
  end
endmodule
